// File: rtl/ppu_quant_pkg.sv
// Shared definitions for the PPU quantizer: mode codes, FSM states and the
// lane/row/width defaults shared with the matrix-multiply controller.
package ppu_quant_pkg;
   localparam int VL_DEF    = 8;
   localparam int AD_DEF    = 8;
   localparam int ACC_W_DEF = 24;

   typedef enum logic [1:0] {
      MODE_INT8     = 2'd0,
      MODE_INT4     = 2'd1,
      MODE_INT4_VSQ = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAX   = 2'd1,
      S_SHIFT = 2'd2,
      S_CALC  = 2'd3
   } state_e;
endpackage

// File: rtl/ppu_quant_if.sv
// PPU bus between the controller (master) and the quantizer (slave):
// tile-start/mode/accumulator rows in, output-RAM write port and status out.
interface ppu_quant_if #(
   parameter int VL     = 8,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 8,
   parameter int SF_W   = 5,
   parameter int ADDR_W = 16
);
   logic                  i_ppu_start;
   logic [1:0]            i_mode;
   logic [ACC_W*VL-1:0]   i_acc_data;
   logic                  o_wr_en;
   logic [ADDR_W-1:0]     o_wr_addr;
   logic [OUT_W*VL-1:0]   o_wr_data;
   logic [SF_W-1:0]       o_wr_sf;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_err;

   modport master (
      output i_ppu_start, i_mode, i_acc_data,
      input  o_wr_en, o_wr_addr, o_wr_data, o_wr_sf, o_busy, o_done, o_err
   );

   modport slave (
      input  i_ppu_start, i_mode, i_acc_data,
      output o_wr_en, o_wr_addr, o_wr_data, o_wr_sf, o_busy, o_done, o_err
   );
endinterface

// File: rtl/ppu_quant_lane_q.sv
// One accumulator lane: clamped |x| for max tracking, and shift/saturate of
// the stage-1 value. PPU_ROUND_EN adds round-half-up before the shift.
module ppu_lane_q
   import ppu_quant_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = 8,
   parameter int SF_W  = 5
) (
   input  logic [ACC_W-1:0] i_x,
   output logic [ACC_W-1:0] o_abs,
   input  logic [ACC_W-1:0] i_xq,
   input  logic [SF_W-1:0]  i_sh,
   input  logic             i_q4,
   output logic [OUT_W-1:0] o_q
);
   localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};

   logic signed [ACC_W:0] w_ext, w_rnd, w_shr, w_hi, w_lo, w_sat;

   // The most negative value has no positive twin; clamp it
   always_comb begin
      o_abs = i_x;
      if (i_x == MIN_NEG)
         o_abs = MAX_POS;
      else if (i_x[ACC_W-1])
         o_abs = -i_x;
   end

   assign w_ext = {i_xq[ACC_W-1], i_xq};

`ifdef PPU_ROUND_EN
   logic signed [ACC_W:0] w_half;
   assign w_half = (i_sh == '0) ? '0 : ((ACC_W+1)'(1) << (i_sh - SF_W'(1)));
   assign w_rnd  = w_ext + w_half;
`else
   assign w_rnd  = w_ext;
`endif

   assign w_shr = w_rnd >>> i_sh;
   assign w_hi  = i_q4 ? (ACC_W+1)'(7) : (ACC_W+1)'(127);
   assign w_lo  = ~w_hi;

   always_comb begin
      w_sat = w_shr;
      if (w_shr > w_hi)
         w_sat = w_hi;
      else if (w_shr < w_lo)
         w_sat = w_lo;
   end

   assign o_q = w_sat[OUT_W-1:0];
endmodule

// File: rtl/ppu_quant.sv
// PPU quantizer: per-tensor max pass + calc pass (INT8/INT4) or single-pass
// per-row VSQ, two-stage write pipeline into the output RAM.
module ppu_quant
   import ppu_quant_pkg::*;
#(
   parameter int VL     = VL_DEF,
   parameter int AD     = AD_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int TILES  = 4,
   parameter int OUT_W  = 8,
   parameter int SF_W   = 5,
   parameter int ADDR_W = 16
) (
   input  logic      i_clk,
   input  logic      i_rst,
   ppu_quant_if.slave bus
);
   localparam int RW = (AD > 1) ? $clog2(AD) : 1;
   localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;

   function automatic logic [SF_W-1:0] f_shift(input logic [ACC_W-1:0] a, input logic q4);
      logic [SF_W-1:0] bl, qm1;
      bl = '0;
      for (int i = 0; i < ACC_W; i++)
         if (a[i]) bl = SF_W'(i + 1);
      qm1 = q4 ? SF_W'(3) : SF_W'(7);
      return (bl > qm1) ? bl - qm1 : '0;
   endfunction

   state_e                    r_state, w_nxt;
   mode_e                     r_mode;
   logic                      r_strm, r_err;
   logic [RW-1:0]             r_row;
   logic [TW-1:0]             r_tile;
   logic [ACC_W-1:0]          r_amax, w_rmax, r_s1_rmax;
   logic [SF_W-1:0]           r_shift, w_sh, r_wr_sf;
   logic [2:1]                r_vld_pipe;
   logic                      w_vld0, w_start_ok, w_start_err, w_last_row, w_last_tile, w_q4;
   logic [VL-1:0][ACC_W-1:0]  w_abs, r_s1_data;
   logic [VL-1:0][OUT_W-1:0]  w_q, r_wr_data;
   logic [ADDR_W-1:0]         w_addr0, r_s1_addr, r_wr_addr;
   logic                      r_s1_last, r_done;

   // A start is only legal once the current tile's rows have all arrived
   assign w_start_ok  = bus.i_ppu_start & ~r_strm;
   assign w_start_err = bus.i_ppu_start & r_strm;
   assign w_last_row  = r_strm & (r_row == RW'(AD - 1));
   assign w_last_tile = (r_tile == TW'(TILES - 1));
   assign w_q4        = (r_mode == MODE_INT4) | (r_mode == MODE_INT4_VSQ);
   assign w_vld0      = (r_state == S_CALC) & r_strm;
   assign w_addr0     = ADDR_W'(r_tile) * ADDR_W'(AD) + ADDR_W'(r_row);

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_nxt = (bus.i_mode == MODE_INT4_VSQ) ? S_CALC : S_MAX;
         S_MAX:   if (w_last_row && w_last_tile) w_nxt = S_SHIFT;
         S_SHIFT: w_nxt = S_CALC;
         S_CALC:  if (w_last_row && w_last_tile) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_rmax = '0;
      for (int g = 0; g < VL; g++)
         if (w_abs[g] > w_rmax) w_rmax = w_abs[g];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_mode  <= MODE_INT8;
         r_strm  <= 1'b0;
         r_row   <= '0;
         r_tile  <= '0;
         r_amax  <= '0;
         r_shift <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_start_err) r_err <= 1'b1;
         if (w_start_ok) begin
            r_strm <= 1'b1;
            r_row  <= '0;
            if (r_state == S_IDLE) begin
               r_mode <= mode_e'(bus.i_mode);
               r_amax <= '0;
            end
         end else if (r_strm) begin
            r_row <= r_row + 1'b1;
            if (w_last_row) begin
               r_strm <= 1'b0;
               r_tile <= w_last_tile ? '0 : r_tile + 1'b1;
            end
         end
         if (r_state == S_MAX && r_strm && w_rmax > r_amax) r_amax <= w_rmax;
         if (r_state == S_SHIFT) r_shift <= f_shift(r_amax, w_q4);
      end
   end

   // VSQ derives the shift from the row max carried alongside stage 1
   assign w_sh = (r_mode == MODE_INT4_VSQ) ? f_shift(r_s1_rmax, 1'b1) : r_shift;

   for (genvar g = 0; g < VL; g++) begin : g_lane
      ppu_lane_q #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SF_W(SF_W)) u_lane (
         .i_x   (bus.i_acc_data[g*ACC_W +: ACC_W]),
         .o_abs (w_abs[g]),
         .i_xq  (r_s1_data[g]),
         .i_sh  (w_sh),
         .i_q4  (w_q4),
         .o_q   (w_q[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld_pipe <= '0;
         r_s1_data  <= '0;
         r_s1_rmax  <= '0;
         r_s1_addr  <= '0;
         r_s1_last  <= 1'b0;
         r_wr_data  <= '0;
         r_wr_addr  <= '0;
         r_wr_sf    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[1], w_vld0};
         r_done     <= r_vld_pipe[1] & r_s1_last;
         if (w_vld0) begin
            r_s1_data <= bus.i_acc_data;
            r_s1_rmax <= w_rmax;
            r_s1_addr <= w_addr0;
            r_s1_last <= w_last_row & w_last_tile;
         end
         if (r_vld_pipe[1]) begin
            r_wr_data <= w_q;
            r_wr_addr <= r_s1_addr;
            r_wr_sf   <= w_sh;
         end
      end
   end

   assign bus.o_wr_en   = r_vld_pipe[2];
   assign bus.o_wr_addr = r_wr_addr;
   assign bus.o_wr_data = r_wr_data;
   assign bus.o_wr_sf   = r_wr_sf;
   assign bus.o_done    = r_done;
   assign bus.o_err     = r_err;
   assign bus.o_busy    = (r_state != S_IDLE) | (|r_vld_pipe);
endmodule
